// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and width helpers for the parametrised FIFO
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;

    // Pointer width; a depth of 1 would give zero bits, so clamp to 1
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit to represent the full count DEPTH
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, one write port and one registered read port
module fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [ptr_w(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic                     i_re,
    input  logic [ptr_w(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]       o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array is left unreset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Output register holds the last popped word until the next read
    always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy, threshold flags and sticky errors
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if ((DEPTH < 2) || (DEPTH > 1024) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 in 2..1024");
    end
    if ((AF_LEVEL < 0) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL must be within 0..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL must be within 0..DEPTH-1");
    end

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_ovf_evt;
    logic          w_unf_evt;

    // A full FIFO still takes a write when a read frees a slot in the same cycle
    assign w_rd_acc  = rd_en & ~empty;
    assign w_wr_acc  = wr_en & (~full | w_rd_acc);
    assign w_ovf_evt = wr_en & ~w_wr_acc;
    assign w_unf_evt = rd_en & empty;

    // Pointers wrap naturally at DEPTH; occupancy moves only on unbalanced traffic
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= (w_wr_acc & ~w_rd_acc) ? r_count + CW'(1) :
                       (w_rd_acc & ~w_wr_acc) ? r_count - CW'(1) : r_count;
        end
    end

    // Read strobe plus sticky errors; a new error event outranks clr_err
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= w_ovf_evt | (r_overflow & ~clr_err);
            r_underflow <= w_unf_evt | (r_underflow & ~clr_err);
        end
    end

    fifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_wr_acc & ~rst),
        .i_waddr(r_wr_ptr),
        .i_wdata(wr_data),
        .i_re   (w_rd_acc & ~rst),
        .i_raddr(r_rd_ptr),
        .o_rdata(rd_data)
    );

    assign rd_valid     = r_rd_valid;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign count        = r_count;
    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed vector bench for the default 8x8 FIFO
module tb_sync_fifo_param;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        logic [3:0] cnt;
        logic       ovf;
        logic       unf;
        logic       rv;
        logic [7:0] rdat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    function automatic vec_t mk(input logic r, input logic w, input logic [7:0] d,
                                input logic rr, input logic c, input logic [3:0] n,
                                input logic o, input logic u, input logic v,
                                input logic [7:0] q);
        vec_t x;
        x.rst = r; x.wr = w; x.wd = d; x.rd = rr; x.clr = c;
        x.cnt = n; x.ovf = o; x.unf = u; x.rv = v; x.rdat = q;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Flags are checked against the bench's own view of occupancy (AF=6, AE=2)
    task automatic apply(input string nm, input vec_t v);
        @(negedge clk);
        rst = v.rst; wr_en = v.wr; wr_data = v.wd; rd_en = v.rd; clr_err = v.clr;
        @(posedge clk);
        #1;
        chk({nm, ".count"}, 32'(count), 32'(v.cnt));
        chk({nm, ".full"}, 32'(full), 32'(v.cnt == 4'd8));
        chk({nm, ".empty"}, 32'(empty), 32'(v.cnt == 4'd0));
        chk({nm, ".afull"}, 32'(almost_full), 32'(v.cnt >= 4'd6));
        chk({nm, ".aempty"}, 32'(almost_empty), 32'(v.cnt <= 4'd2));
        chk({nm, ".ovf"}, 32'(overflow), 32'(v.ovf));
        chk({nm, ".unf"}, 32'(underflow), 32'(v.unf));
        chk({nm, ".rvalid"}, 32'(rd_valid), 32'(v.rv));
        chk({nm, ".rdata"}, 32'(rd_data), 32'(v.rdat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        // Reset, idle, fill 0x11..0x18, drain in order
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 8'(8'h11 + i), 0, 0, 4'(i + 1), 0, 0, 0, 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'(7 - i), 0, 0, 1, 8'(8'h11 + i)));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 8'h18));
        foreach (tbl[i]) apply($sformatf("basic[%0d]", i), tbl[i]);

        // Overflow: 0xAA is dropped, queue contents intact, clear works
        for (int i = 0; i < 8; i++)
            apply("ovf_fill", mk(0, 1, 8'(8'h11 + i), 0, 0, 4'(i + 1), 0, 0, 0, 8'h18));
        apply("ovf_drop", mk(0, 1, 8'hAA, 0, 0, 4'd8, 1, 0, 0, 8'h18));
        for (int i = 0; i < 8; i++)
            apply("ovf_read", mk(0, 0, 8'h00, 1, 0, 4'(7 - i), 1, 0, 1, 8'(8'h11 + i)));
        apply("ovf_clr", mk(0, 0, 8'h00, 0, 1, 4'd0, 0, 0, 0, 8'h18));
        apply("clr_vs_unf", mk(0, 0, 8'h00, 1, 1, 4'd0, 0, 1, 0, 8'h18));
        apply("unf_clr", mk(0, 0, 8'h00, 0, 1, 4'd0, 0, 0, 0, 8'h18));

        // Full-rate streaming through a full FIFO, pointers wrap twice
        for (int i = 0; i < 8; i++)
            apply("st_fill", mk(0, 1, 8'(8'h20 + i), 0, 0, 4'(i + 1), 0, 0, 0, 8'h18));
        for (int i = 0; i < 16; i++)
            apply("st_both", mk(0, 1, 8'(8'h28 + i), 1, 0, 4'd8, 0, 0, 1, 8'(8'h20 + i)));
        for (int i = 0; i < 8; i++)
            apply("st_drain", mk(0, 0, 8'h00, 1, 0, 4'(7 - i), 0, 0, 1, 8'(8'h30 + i)));

        // Read+write on empty: write lands, read rejected, no bypass
        apply("emp_both", mk(0, 1, 8'h5C, 1, 0, 4'd1, 0, 1, 0, 8'h37));
        apply("emp_read", mk(0, 0, 8'h00, 1, 0, 4'd0, 0, 1, 1, 8'h5C));
        apply("emp_clr", mk(0, 0, 8'h00, 0, 1, 4'd0, 0, 0, 0, 8'h5C));

        // Reset mid-operation discards contents and the concurrent read
        for (int i = 0; i < 3; i++)
            apply("rst_fill", mk(0, 1, 8'(8'h61 + i), 0, 0, 4'(i + 1), 0, 0, 0, 8'h5C));
        apply("rst_hit", mk(1, 0, 8'h00, 1, 0, 4'd0, 0, 0, 0, 8'h00));
        apply("rst_after", mk(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 8'h00));
        apply("rst_wr", mk(0, 1, 8'h77, 0, 0, 4'd1, 0, 0, 0, 8'h00));
        apply("rst_rd", mk(0, 0, 8'h00, 1, 0, 4'd0, 0, 0, 1, 8'h77));
        apply("rst_idle", mk(0, 0, 8'h00, 0, 0, 4'd0, 0, 0, 0, 8'h77));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
